// File: rtl/dsram_responder.sv
// Purpose: single-port data SRAM plus a small config block (LED, SW, TIMER, ERR) behind one CPU data port.
// Latency: rdata is registered; a request in cycle N returns the read-first word in cycle N+1.
// Backpressure: none; one request is accepted every cycle, and rdata holds while no request is presented.
//
// Ports:
//   clk             single clock, rising edge
//   reset           synchronous, active-low
//   cpu_data_en     request valid this cycle
//   cpu_data_wen    byte write enables (0 = read)
//   cpu_data_addr   byte address; bits [1:0] do not affect which word is addressed
//   cpu_data_wdata  write data
//   cpu_data_rdata  registered read data
//   sw              asynchronous switch inputs
//   led             low half of the LED register
//   err_cnt         saturating count of unmapped accesses
module dsram_responder #(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_data_en,
    input  logic [3:0]  cpu_data_wen,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    input  logic [7:0]  sw,
    output logic [15:0] led,
    output logic [7:0]  err_cnt
);

    localparam int          AW       = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_MASK = ~((32'(RAM_WORDS) << 2) - 32'd1);

    localparam logic [1:0] OFF_LED   = 2'd0;
    localparam logic [1:0] OFF_SW    = 2'd1;
    localparam logic [1:0] OFF_TIMER = 2'd2;
    localparam logic [1:0] OFF_ERR   = 2'd3;

    // Byte-lane merge shared by the RAM-style writable registers.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Storage. The RAM array deliberately has no reset.
    logic [31:0] mem [RAM_WORDS];

    logic [31:0] rdata_q, rdata_d;
    logic [31:0] led_q,   led_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  err_q,   err_d;
    logic [7:0]  sw_meta_q, sw_sync_q;

    // Decode
    logic          ram_hit;
    logic          conf_hit;
    logic          req_ok;
    logic          wr;
    logic [AW-1:0] ram_idx;
    logic [1:0]    conf_off;
    logic [31:0]   ram_rd;
    logic          ram_we;

    assign ram_hit  = ((cpu_data_addr & RAM_MASK) == RAM_BASE);
    assign conf_hit = !ram_hit && (cpu_data_addr[31:4] == CONF_BASE[31:4]);
    // A request seen while reset is asserted is dropped entirely.
    assign req_ok   = cpu_data_en && reset;
    assign wr       = |cpu_data_wen;
    assign ram_idx  = cpu_data_addr[AW+1:2];
    assign conf_off = cpu_data_addr[3:2];
    // Read of the pre-write contents gives read-first behaviour.
    assign ram_rd   = mem[ram_idx];

    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        err_d   = err_q;
        ram_we  = 1'b0;
        if (req_ok) begin
            if (ram_hit) begin
                rdata_d = ram_rd;
                ram_we  = wr;
            end else if (conf_hit) begin
                case (conf_off)
                    OFF_LED: begin
                        rdata_d = led_q;
                        if (wr) led_d = lane_merge(led_q, cpu_data_wdata, cpu_data_wen);
                    end
                    OFF_SW: begin
                        rdata_d = {24'b0, sw_sync_q};
                    end
                    OFF_TIMER: begin
                        // Value before this cycle's increment/write; a write
                        // replaces the increment for this cycle.
                        rdata_d = timer_q;
                        if (wr) timer_d = lane_merge(timer_q, cpu_data_wdata, cpu_data_wen);
                    end
                    default: begin
                        rdata_d = {24'b0, err_q};
                        if (wr) err_d = 8'h00;
                    end
                endcase
            end else begin
                rdata_d = 32'h0;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q   <= 32'h0;
            led_q     <= 32'h0;
            timer_q   <= 32'h0;
            err_q     <= 8'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cpu_data_wen[i]) mem[ram_idx][8*i +: 8] <= cpu_data_wdata[8*i +: 8];
            end
        end
    end

    assign cpu_data_rdata = rdata_q;
    assign led            = led_q[15:0];
    assign err_cnt        = err_q;

endmodule

// File: tb/tb_dsram_responder.sv
module tb_dsram_responder;

    localparam logic [31:0] CONF   = 32'hBFAF_F000;
    localparam logic [31:0] A_LED  = CONF + 32'h0;
    localparam logic [31:0] A_SW   = CONF + 32'h4;
    localparam logic [31:0] A_TMR  = CONF + 32'h8;
    localparam logic [31:0] A_ERR  = CONF + 32'hC;
    localparam logic [31:0] A_UNM  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_data_en;
    logic [3:0]  cpu_data_wen;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [31:0] cpu_data_rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [7:0]  err_cnt;

    dsram_responder dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_data_en    (cpu_data_en),
        .cpu_data_wen   (cpu_data_wen),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_rdata (cpu_data_rdata),
        .sw             (sw),
        .led            (led),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic        issue_chk = 1'b0;
    logic        mon_vld   = 1'b0;

    always @(posedge clk) mon_vld <= issue_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one cycle after a checked request, rdata must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got %h expected none", cpu_data_rdata);
                end else begin
                    chk("sb_rdata", cpu_data_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one request for one cycle; called at posedge+1, returns at next posedge+1.
    task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit do_chk, input logic [31:0] exp);
        cpu_data_en    = 1'b1;
        cpu_data_wen   = wen;
        cpu_data_addr  = addr;
        cpu_data_wdata = wdata;
        issue_chk      = do_chk;
        if (do_chk) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cpu_data_en = 1'b0;
        issue_chk   = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_data_en = 1'b0;
        issue_chk   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        cpu_data_en    = 1'b0;
        cpu_data_wen   = 4'h0;
        cpu_data_addr  = 32'h0;
        cpu_data_wdata = 32'h0;
        sw             = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", cpu_data_rdata, 32'h0);
        chk("rst_led",   {16'h0, led},   32'h0);
        chk("rst_err",   {24'h0, err_cnt}, 32'h0);

        // First non-reset cycle: timer reads 0, then 1.
        reset = 1'b1;
        req(4'h0, A_TMR, 32'h0, 1, 32'h0);
        req(4'h0, A_TMR, 32'h0, 1, 32'h1);

        // Byte-lane RAM writes.
        req(4'hF, 32'h100, 32'h1122_3344, 0, 32'h0);
        req(4'h2, 32'h100, 32'hAABB_CCDD, 1, 32'h1122_3344);
        req(4'h0, 32'h100, 32'h0,         1, 32'h1122_CC44);

        // Read-first back-to-back.
        req(4'hF, 32'h200, 32'h0,         0, 32'h0);
        req(4'hF, 32'h200, 32'hDEAD_BEEF, 1, 32'h0);
        req(4'h0, 32'h200, 32'h0,         1, 32'hDEAD_BEEF);
        idle(2);
        chk("rdata_hold", cpu_data_rdata, 32'hDEAD_BEEF);

        // Top word of RAM and first address past it.
        req(4'hF, 32'h3FFC, 32'hCAFE_F00D, 0, 32'h0);
        req(4'h0, 32'h3FFC, 32'h0,         1, 32'hCAFE_F00D);
        req(4'h0, 32'h4000, 32'h0,         1, 32'h0);
        chk("err_one", {24'h0, err_cnt}, 32'h1);

        // Timer wrap.
        req(4'hF, A_TMR, 32'hFFFF_FFFE, 0, 32'h0);
        idle(1);
        req(4'h0, A_TMR, 32'h0, 1, 32'hFFFF_FFFF);
        req(4'h0, A_TMR, 32'h0, 1, 32'h0000_0000);

        // Unmapped saturation and clear.
        for (int i = 0; i < 300; i++) req(4'h0, A_UNM, 32'h0, 1, 32'h0);
        chk("err_sat", {24'h0, err_cnt}, 32'hFF);
        req(4'h0, A_ERR, 32'h0, 1, 32'h0000_00FF);
        req(4'h1, A_ERR, 32'h0, 1, 32'h0000_00FF);
        chk("err_clr", {24'h0, err_cnt}, 32'h0);
        req(4'hF, CONF + 32'h10, 32'h1234_5678, 1, 32'h0);
        chk("err_unm_wr", {24'h0, err_cnt}, 32'h1);

        // Switch synchronizer.
        sw = 8'h5A;
        idle(1);
        req(4'h0, A_SW, 32'h0, 1, 32'h0);
        req(4'h0, A_SW, 32'h0, 1, 32'h0000_005A);

        // LED.
        req(4'hF, A_LED, 32'h0001_F00F, 1, 32'h0);
        chk("led_out", {16'h0, led}, 32'h0000_F00F);
        req(4'h8, A_LED, 32'hAA00_0000, 1, 32'h0001_F00F);
        req(4'h0, A_LED, 32'h0, 1, 32'hAA01_F00F);

        // Reset mid-stream during an LED write.
        reset = 1'b0;
        req(4'hF, A_LED, 32'h1234_5678, 1, 32'h0);
        reset = 1'b1;
        chk("mid_led", {16'h0, led}, 32'h0);
        chk("mid_err", {24'h0, err_cnt}, 32'h0);
        req(4'h0, A_TMR, 32'h0, 1, 32'h0);
        req(4'h0, A_LED, 32'h0, 1, 32'h0);

        idle(3);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
